// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP status reader: scan states,
// DRP bus widths and the default pair of status register addresses.
package xadc_pkg;

  localparam int DRP_DATA_W = 16;
  localparam int DRP_ADDR_W = 7;

  localparam logic [DRP_ADDR_W-1:0] ADDR_STAT_CH0 = 7'h16;
  localparam logic [DRP_ADDR_W-1:0] ADDR_STAT_CH1 = 7'h17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ACC,
    ST_OUT
  } state_t;

  // Width of a channel index into the accumulator bank (at least one bit).
  function automatic int idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/xadc_promediador.sv
// Per-channel accumulator/counter bank. The addressed channel's running
// sum plus the incoming sample is presented combinationally so the
// controller can load the mean in the same cycle the last sample lands.
module xadc_promediador
  import xadc_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [idx_w(N_CH)-1:0]       k,
  input  logic                         add,
  input  logic                         clear,
  input  logic [DATA_W-1:0]            sample,
  output logic                         done,
  output logic [DATA_W-1:0]            mean
);

  localparam int K_W   = idx_w(N_CH);
  localparam int DEPTH = 2 ** K_W;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc [DEPTH];
  logic [CNT_W-1:0] cnt [DEPTH];
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] shifted;

  // Sum including the sample being added, and the truncated mean of it.
  always_comb begin
    sum     = acc[k] + ACC_W'(sample);
    shifted = sum >> AVG_LOG2;
    mean    = shifted[DATA_W-1:0];
    done    = (cnt[k] == CNT_LAST);
  end

  // Accumulate into the addressed channel, or zero it when its window closes.
  // NOTE: the bank is tiny and must start from zero after every reset, so it
  // is reset like ordinary flops instead of being treated as uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (add) begin
      if (clear) begin
        acc[k] <= '0;
        cnt[k] <= '0;
      end else begin
        acc[k] <= sum;
        cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/xadc_drp_lector.sv
// Reads the XADC status registers over DRP after every end-of-conversion,
// averages 2^AVG_LOG2 results per channel and hands them downstream with
// a valid/ready handshake. Overrun and timeout are sticky error flags.
module xadc_drp_lector
  import xadc_pkg::*;
#(
  parameter int                           N_CH     = 2,
  parameter logic [N_CH*DRP_ADDR_W-1:0]   CH_ADDR  = {ADDR_STAT_CH1, ADDR_STAT_CH0},
  parameter int                           DATA_W   = 12,
  parameter int                           AVG_LOG2 = 0,
  parameter int                           TIMEOUT  = 64
) (
  input  logic                  clk_78MHz_i,
  input  logic                  reset_i,
  input  logic                  eoc_i,
  input  logic                  drdy_i,
  input  logic [DRP_DATA_W-1:0] do_i,
  output logic                  den_o,
  output logic                  dwe_o,
  output logic [DRP_DATA_W-1:0] di_o,
  output logic [DRP_ADDR_W-1:0] daddr_o,
  output logic [DATA_W-1:0]     data_o,
  output logic [2:0]            chan_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  localparam int         K_W     = idx_w(N_CH);
  localparam logic [2:0] LAST_CH = 3'(N_CH - 1);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t            state;
  logic [2:0]        k;
  logic [2:0]        next_k;
  logic [9:0]        tcnt;
  logic [DATA_W-1:0] sample;
  logic              advance;
  logic              avg_add;
  logic              avg_done;
  logic [DATA_W-1:0] avg_mean;

  // Read-only DRP master: the write side is tied off.
  assign dwe_o = 1'b0;
  assign di_o  = '0;

  if (DATA_W < DRP_DATA_W) begin : g_unused_do
    logic unused_do_bits;
    assign unused_do_bits = ^do_i[DRP_DATA_W-DATA_W-1:0];
  end

  function automatic logic [DRP_ADDR_W-1:0] addr_of(input logic [2:0] idx);
    return CH_ADDR[DRP_ADDR_W*int'(idx) +: DRP_ADDR_W];
  endfunction

  // Decide when the current channel is finished and the scan moves on.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    advance = 1'b0;
    avg_add = (state == ST_ACC);
    next_k  = k + 3'd1;
    unique case (state)
      ST_WAIT: advance = !drdy_i && (tcnt == TO_LAST);
      ST_ACC:  advance = !avg_done;
      ST_OUT:  advance = ready_i;
      default: advance = 1'b0;
    endcase
  end

  xadc_promediador #(
    .N_CH     (N_CH),
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_promediador (
    .clk    (clk_78MHz_i),
    .rst_n  (reset_i),
    .k      (k[K_W-1:0]),
    .add    (avg_add),
    .clear  (avg_done),
    .sample (sample),
    .done   (avg_done),
    .mean   (avg_mean)
  );

  // Scan controller with registered DRP strobe, result and error flags.
  // NOTE: state is updated with non-blocking assignments only, so every
  // branch sees the values from before this clock edge.
  always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= ST_IDLE;
      k         <= 3'd0;
      tcnt      <= '0;
      sample    <= '0;
      den_o     <= 1'b0;
      daddr_o   <= addr_of(3'd0);
      data_o    <= '0;
      chan_o    <= 3'd0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      den_o <= 1'b0;
      if (eoc_i && state != ST_IDLE) overrun_o <= 1'b1;

      unique case (state)
        ST_IDLE: if (eoc_i) begin
          k       <= 3'd0;
          daddr_o <= addr_of(3'd0);
          den_o   <= 1'b1;
          state   <= ST_REQ;
        end
        ST_REQ: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drdy_i) begin
            sample <= do_i[DRP_DATA_W-1 -: DATA_W];
            state  <= ST_ACC;
          end else if (tcnt == TO_LAST) begin
            timeout_o <= 1'b1;
          end else begin
            tcnt <= tcnt + 10'd1;
          end
        end
        ST_ACC: if (avg_done) begin
          data_o  <= avg_mean;
          chan_o  <= k;
          valid_o <= 1'b1;
          state   <= ST_OUT;
        end
        ST_OUT: if (ready_i) valid_o <= 1'b0;
        default: state <= ST_IDLE;
      endcase

      // Next-channel step: issue the following read or fall back to idle.
      if (advance) begin
        if (k == LAST_CH) begin
          state <= ST_IDLE;
        end else begin
          k       <= next_k;
          daddr_o <= addr_of(next_k);
          den_o   <= 1'b1;
          state   <= ST_REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_xadc_drp_lector.sv
// Bench for xadc_drp_lector: two instances (2 channels without averaging,
// 8 channels averaging 4 reads), each fed by a behavioural DRP responder.
// Expected outputs come from per-EOC arithmetic on the responder contents.
module tb_xadc_drp_lector;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] d;
  } out_t;

  localparam logic [55:0] ADDR_B = {7'h27, 7'h26, 7'h25, 7'h24,
                                    7'h23, 7'h22, 7'h21, 7'h20};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_CH=2, AVG_LOG2=0.
  logic        eoc_a = 1'b0, drdy_a = 1'b0, ready_a = 1'b1;
  logic [15:0] do_a = '0;
  wire         den_a, dwe_a, valid_a, overrun_a, timeout_a;
  wire  [15:0] di_a;
  wire  [6:0]  daddr_a;
  wire  [11:0] data_a;
  wire  [2:0]  chan_a;

  // Instance B: N_CH=8, AVG_LOG2=2.
  logic        eoc_b = 1'b0, drdy_b = 1'b0, ready_b = 1'b1;
  logic [15:0] do_b = '0;
  wire         den_b, dwe_b, valid_b, overrun_b, timeout_b;
  wire  [15:0] di_b;
  wire  [6:0]  daddr_b;
  wire  [11:0] data_b;
  wire  [2:0]  chan_b;

  xadc_drp_lector dut_a (
    .clk_78MHz_i (clk),    .reset_i   (rst_n),     .eoc_i   (eoc_a),
    .drdy_i      (drdy_a), .do_i      (do_a),      .den_o   (den_a),
    .dwe_o       (dwe_a),  .di_o      (di_a),      .daddr_o (daddr_a),
    .data_o      (data_a), .chan_o    (chan_a),    .valid_o (valid_a),
    .ready_i     (ready_a),.overrun_o (overrun_a), .timeout_o (timeout_a)
  );

  xadc_drp_lector #(.N_CH(8), .CH_ADDR(ADDR_B), .AVG_LOG2(2)) dut_b (
    .clk_78MHz_i (clk),    .reset_i   (rst_n),     .eoc_i   (eoc_b),
    .drdy_i      (drdy_b), .do_i      (do_b),      .den_o   (den_b),
    .dwe_o       (dwe_b),  .di_o      (di_b),      .daddr_o (daddr_b),
    .data_o      (data_b), .chan_o    (chan_b),    .valid_o (valid_b),
    .ready_i     (ready_b),.overrun_o (overrun_b), .timeout_o (timeout_b)
  );

  // DRP responders: register contents, latency and an optional silent address.
  logic [15:0] mem_a [128];
  logic [15:0] mem_b [128];
  int          lat_a = 2, lat_b = 2, cd_a = 0, cd_b = 0;
  logic [6:0]  pend_a = '0, pend_b = '0, mute_addr_a = 7'h16;
  bit          mute_a = 1'b0, rand_ready_a = 1'b0;

  always @(posedge clk) begin
    #1;
    drdy_a = 1'b0;
    do_a   = 16'($urandom);
    if (cd_a > 0) begin
      cd_a--;
      if (cd_a == 0) begin drdy_a = 1'b1; do_a = mem_a[pend_a]; end
    end
    if (den_a && !(mute_a && daddr_a == mute_addr_a)) begin cd_a = lat_a; pend_a = daddr_a; end
  end

  always @(posedge clk) begin
    #1;
    drdy_b = 1'b0;
    do_b   = 16'($urandom);
    if (cd_b > 0) begin
      cd_b--;
      if (cd_b == 0) begin drdy_b = 1'b1; do_b = mem_b[pend_b]; end
    end
    if (den_b) begin cd_b = lat_b; pend_b = daddr_b; end
  end

  // Monitors: completed transfers and issued DRP reads.
  out_t       obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  logic [6:0] addr_log_a[$];
  int         den_cnt_a = 0;
  int         sum_b [8];
  int         cnt_b [8];

  always @(negedge clk) begin
    if (valid_a && ready_a) obs_a.push_back({chan_a, data_a});
    if (valid_b && ready_b) obs_b.push_back({chan_b, data_b});
    if (den_a) begin addr_log_a.push_back(daddr_a); den_cnt_a++; end
  end

  int compared = 0, mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready_a) ready_a = 1'($urandom_range(0, 1));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_eoc_a();
    eoc_a = 1'b1; tick(); eoc_a = 1'b0;
  endtask

  task automatic pulse_eoc_b();
    eoc_b = 1'b1; tick(); eoc_b = 1'b0;
  endtask

  // Reference for A: every unmuted channel yields its top 12 bits.
  task automatic expect_scan_a();
    logic [6:0] a;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 7'h16 : 7'h17;
      if (!(mute_a && a == mute_addr_a)) exp_a.push_back({3'(k), mem_a[a][15:4]});
    end
  endtask

  // Reference for B: running sum per channel, mean of every 4 reads.
  task automatic expect_scan_b();
    for (int k = 0; k < 8; k++) begin
      sum_b[k] += int'(mem_b[32 + k][15:4]);
      cnt_b[k]++;
      if (cnt_b[k] == 4) begin
        exp_b.push_back({3'(k), 12'(sum_b[k] / 4)});
        sum_b[k] = 0;
        cnt_b[k] = 0;
      end
    end
  endtask

  task automatic wait_obs_a(input int n, input int budget);
    for (int c = 0; c < budget && obs_a.size() < n; c++) tick();
  endtask

  task automatic wait_obs_b(input int n, input int budget);
    for (int c = 0; c < budget && obs_b.size() < n; c++) tick();
  endtask

  task automatic compare_a(input string tag);
    check({tag, ".count"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(obs_a[i]), 32'(exp_a[i]));
    obs_a.delete();
    exp_a.delete();
  endtask

  task automatic compare_b(input string tag);
    check({tag, ".count"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(obs_b[i]), 32'(exp_b[i]));
    obs_b.delete();
    exp_b.delete();
  endtask

  initial begin
    logic [11:0] d0;
    logic [2:0]  c0;
    int          den0;
    bit          stable;

    foreach (mem_a[i]) mem_a[i] = '0;
    foreach (mem_b[i]) mem_b[i] = '0;
    foreach (sum_b[i]) begin sum_b[i] = 0; cnt_b[i] = 0; end

    // Reset values while reset is held.
    ticks(3);
    check("rst.den",     den_a,     0);
    check("rst.valid",   valid_a,   0);
    check("rst.data",    data_a,    0);
    check("rst.chan",    chan_a,    0);
    check("rst.daddr",   daddr_a,   7'h16);
    check("rst.daddr_b", daddr_b,   7'h20);
    check("rst.overrun", overrun_a, 0);
    check("rst.timeout", timeout_a, 0);
    check("rst.dwe",     dwe_a,     0);
    check("rst.di",      di_a,      0);
    rst_n = 1'b1;
    ticks(2);

    // Directed two-channel read with fixed latency.
    mem_a[7'h16] = 16'hABC0;
    mem_a[7'h17] = 16'h1230;
    addr_log_a.delete();
    expect_scan_a();
    pulse_eoc_a();
    check("lat.den_after_eoc", den_a, 1);
    ticks(3);
    check("lat.valid_cycle4", valid_a, 0);
    tick();
    check("lat.valid_cycle5", valid_a, 1);
    wait_obs_a(2, 100);
    ticks(10);
    check("direct.ch0", 32'(obs_a.size() > 0 ? obs_a[0] : '0), {3'd0, 12'hABC});
    compare_a("direct");
    check("direct.naddr", addr_log_a.size(), 2);
    check("direct.addr0", addr_log_a.size() > 0 ? addr_log_a[0] : 7'h00, 7'h16);
    check("direct.addr1", addr_log_a.size() > 1 ? addr_log_a[1] : 7'h00, 7'h17);

    // Random data with random backpressure.
    rand_ready_a = 1'b1;
    for (int it = 0; it < 6; it++) begin
      mem_a[7'h16] = 16'($urandom);
      mem_a[7'h17] = 16'($urandom);
      expect_scan_a();
      pulse_eoc_a();
      wait_obs_a(2, 300);
      ticks(10);
      compare_a($sformatf("rand%0d", it));
    end
    rand_ready_a = 1'b0;
    ready_a = 1'b1;
    tick();
    check("pre_stall.overrun", overrun_a, 0);

    // Backpressure stall with an EOC arriving mid-stall.
    mem_a[7'h16] = 16'($urandom);
    mem_a[7'h17] = 16'($urandom);
    ready_a = 1'b0;
    expect_scan_a();
    pulse_eoc_a();
    for (int c = 0; c < 50 && !valid_a; c++) tick();
    check("stall.valid", valid_a, 1);
    d0 = data_a;
    c0 = chan_a;
    den0 = den_cnt_a;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      eoc_a = (c == 10);
      tick();
      if (!(valid_a === 1'b1 && data_a === d0 && chan_a === c0)) stable = 1'b0;
    end
    eoc_a = 1'b0;
    check("stall.stable", stable, 1);
    check("stall.no_den", den_cnt_a - den0, 0);
    check("stall.overrun", overrun_a, 1);
    ready_a = 1'b1;
    wait_obs_a(2, 100);
    ticks(10);
    compare_a("stall");

    // Channel 0 never answers: timeout, channel 1 still delivered.
    mem_a[7'h17] = 16'($urandom);
    mute_a = 1'b1;
    expect_scan_a();
    pulse_eoc_a();
    ticks(30);
    check("to.not_early", timeout_a, 0);
    wait_obs_a(1, 200);
    ticks(10);
    check("to.flag", timeout_a, 1);
    compare_a("timeout");
    mute_a = 1'b0;

    // Reset during WAIT, late DRP answer after release.
    lat_a = 5;
    mem_a[7'h16] = 16'hFFF0;
    pulse_eoc_a();
    tick();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    den0 = den_cnt_a;
    ticks(12);
    check("rstwait.outputs", obs_a.size(), 0);
    check("rstwait.valid",   valid_a,   0);
    check("rstwait.data",    data_a,    0);
    check("rstwait.chan",    chan_a,    0);
    check("rstwait.daddr",   daddr_a,   7'h16);
    check("rstwait.no_den",  den_cnt_a - den0, 0);
    check("rstwait.overrun", overrun_a, 0);
    check("rstwait.timeout", timeout_a, 0);
    lat_a = 2;
    obs_a.delete();
    exp_a.delete();

    // Normal operation resumes after that reset.
    mem_a[7'h16] = 16'($urandom);
    mem_a[7'h17] = 16'($urandom);
    expect_scan_a();
    pulse_eoc_a();
    wait_obs_a(2, 100);
    ticks(10);
    compare_a("recover");

    // Instance B: averaging of four reads, ch0 fixed at 1,2,3,4.
    obs_b.delete();
    for (int e = 0; e < 4; e++) begin
      mem_b[32] = 16'(16'h0010 * (e + 1));
      for (int k = 1; k < 8; k++) mem_b[32 + k] = 16'($urandom);
      expect_scan_b();
      if (e == 3) check("avg.none_before_4th", obs_b.size(), 0);
      pulse_eoc_b();
      ticks(199);
    end
    check("avg.ch0", 32'(obs_b.size() > 0 ? obs_b[0] : '0), {3'd0, 12'h002});
    compare_b("avg");

    // Eight more EOCs every 200 cycles with random data.
    for (int e = 0; e < 8; e++) begin
      for (int k = 0; k < 8; k++) mem_b[32 + k] = 16'($urandom);
      expect_scan_b();
      pulse_eoc_b();
      ticks(199);
    end
    wait_obs_b(exp_b.size(), 200);
    compare_b("b2b");
    check("b2b.overrun", overrun_b, 0);
    check("b2b.timeout", timeout_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xadc_drp_lector.md
XADC_DRP_LECTOR -- requirements
Module: xadc_drp_lector

Interface
REQ-001 Parameter N_CH, default 2: number of XADC channels scanned per EOC, legal 1..8.
REQ-002 Parameter CH_ADDR, default {7'h17,7'h16}: packed N_CH x 7-bit DRP status addresses, channel k at bits [7k+6:7k].
REQ-003 Parameter DATA_W, default 12: result width, taken from do_i[15:16-DATA_W], legal 1..16.
REQ-004 Parameter AVG_LOG2, default 0: each output is the mean of 2^AVG_LOG2 conversions per channel, legal 0..4.
REQ-005 Parameter TIMEOUT, default 64: cycles allowed from den_o to drdy_i, legal 4..1023.
REQ-006 clk_78MHz_i  in  1  sole clock; DRP clock of the XADC.
REQ-007 reset_i  in  1  asynchronous, active-low reset.
REQ-008 eoc_i  in  1  XADC end-of-conversion pulse.
REQ-009 drdy_i  in  1  DRP read-data valid.
REQ-010 do_i  in  16  DRP read data.
REQ-011 den_o  out  1  DRP enable, one-cycle pulse.
REQ-012 dwe_o  out  1  DRP write enable, constant 0.
REQ-013 di_o  out  16  DRP write data, constant 16'h0.
REQ-014 daddr_o  out  7  DRP address.
REQ-015 data_o  out  DATA_W  averaged sample.
REQ-016 chan_o  out  3  index k of the channel in data_o.
REQ-017 valid_o  out  1  data_o/chan_o valid.
REQ-018 ready_i  in  1  downstream (FIFO not full) accepts; transfer when valid_o && ready_i.
REQ-019 overrun_o  out  1  sticky: an eoc_i arrived while not IDLE.
REQ-020 timeout_o  out  1  sticky: a DRP read timed out.

Function
REQ-021 States IDLE, REQ, WAIT, ACC, OUT; IDLE -> REQ on eoc_i with k=0.
REQ-022 REQ: den_o=1 for exactly one cycle, daddr_o=CH_ADDR[k], timeout counter cleared; -> WAIT next cycle.
REQ-023 WAIT: on drdy_i capture do_i[15:16-DATA_W] -> ACC; drdy_i in the same cycle as den_o is ignored.
REQ-024 WAIT: after TIMEOUT cycles without drdy_i set timeout_o, discard channel k (no accumulation), go to next-channel step.
REQ-025 ACC: acc[k] += sample, cnt[k] += 1; accumulator width DATA_W+AVG_LOG2, no overflow possible.
REQ-026 ACC: when cnt[k] reaches 2^AVG_LOG2, load data_o=acc[k]>>AVG_LOG2 (truncating), chan_o=k, clear acc[k] and cnt[k], -> OUT; otherwise next-channel step.
REQ-027 OUT: valid_o=1, data_o/chan_o stable until ready_i=1; on transfer valid_o drops next cycle, next-channel step.
REQ-028 Next-channel step: k<N_CH-1 -> k+1, REQ; k=N_CH-1 -> IDLE.
REQ-029 eoc_i in any state other than IDLE sets overrun_o and is dropped; scan in progress unaffected.
REQ-030 eoc_i in the cycle of the IDLE transition back from next-channel step is also dropped (counts as overrun).
REQ-031 AVG_LOG2=0: every read yields one output, latency eoc_i -> valid_o for channel 0 = 3 cycles + DRP latency.
REQ-032 Only transfer needs ready_i; backpressure stalls the scan, never drops a sample.
REQ-033 overrun_o and timeout_o clear only by reset.

Reset
REQ-034 reset_i low asynchronously forces IDLE, k=0, den_o=0, daddr_o=CH_ADDR[0], valid_o=0, data_o=0, chan_o=0, all acc/cnt=0, overrun_o=0, timeout_o=0.
REQ-035 Reset mid-read abandons the DRP transaction; a late drdy_i after release in IDLE is ignored.
REQ-036 Reset deassertion takes effect on the next rising edge; first eoc_i accepted one cycle later.

Structure
REQ-037 Package xadc_pkg holds state encoding, DRP width constants (16-bit data, 7-bit address) and default status addresses 7'h16/7'h17.
REQ-038 Sub-module xadc_promediador (per-channel accumulator/counter bank, index k, clear, done flag) is instantiated once.
REQ-039 XADC primitive is instantiated outside this block; all DRP ports connect straight through.

Verification
REQ-040 N_CH=2, AVG_LOG2=0, DRP model drdy 2 cycles after den, data 16'hABC0/16'h1230, ready_i=1 -> two outputs 12'hABC ch0, 12'h123 ch1, den_o addrs 7'h16 then 7'h17.
REQ-041 AVG_LOG2=2, ch0 reads 16'h0010,16'h0020,16'h0030,16'h0040 (top 12 bits 1,2,3,4) over four EOCs -> one ch0 output 12'h002 after 4th EOC.
REQ-042 ready_i low 20 cycles with valid_o high -> data_o stable, no den_o issued, second eoc_i during stall sets overrun_o.
REQ-043 DRP model never asserts drdy_i for channel 0 -> timeout_o after 64 cycles, channel 1 still read and output.
REQ-044 reset_i low while in WAIT, drdy_i arriving 2 cycles after release -> no output, all outputs at reset values.
REQ-045 N_CH=8, back-to-back EOCs every 200 cycles -> eight outputs chan_o 0..7 per EOC, overrun_o stays 0.
